wired_tlb_maint: RTL and testbench

- Upstream maintenance controller for the TLB CAM array built from per-entry match cells.
- Turns TLBWR, TLBFILL and INVTLB requests into per-entry update strobes plus a broadcast key.
- Keeps a shadow copy of every entry key so INVTLB can be resolved by walking the entries.
- After reset, sweeps all entries invalid, because the match cells are not cleared on reset.

---
 rtl/wired0_defines.sv | 37 +++
 rtl/wired_tlb_inv_cmp.sv | 33 +++
 rtl/wired_tlb_maint.sv | 189 ++++++++++++++++++
 tb/tb_wired_tlb_maint.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wired0_defines.sv
// Shared TLB maintenance definitions: request opcodes, INVTLB op codes,
// default entry count and the per-entry match key.
package wired0_defines;

  localparam int TLB_ENTRIES_DEF = 32;

  typedef enum logic [1:0] {
    TLB_OP_WR   = 2'd0,
    TLB_OP_FILL = 2'd1,
    TLB_OP_INV  = 2'd2,
    TLB_OP_RSVD = 2'd3
  } tlb_maint_op_e;

  localparam logic [4:0] INV_ALL0    = 5'd0;
  localparam logic [4:0] INV_ALL1    = 5'd1;
  localparam logic [4:0] INV_GLB     = 5'd2;
  localparam logic [4:0] INV_NGLB    = 5'd3;
  localparam logic [4:0] INV_ASID    = 5'd4;
  localparam logic [4:0] INV_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GVA     = 5'd6;

  typedef struct packed {
    logic        e;
    logic        huge_page;
    logic        g;
    logic [9:0]  asid;
    logic [18:0] vppn;
  } tlb_key_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WALK = 2'd2,
    ST_RESP = 2'd3
  } maint_state_e;

endpackage

// File: rtl/wired_tlb_inv_cmp.sv
// INVTLB kill predicate for a single entry key. Purely combinational.
module wired_tlb_inv_cmp
  import wired0_defines::*;
(
  input  tlb_key_t    key_i,
  input  logic [4:0]  inv_op_i,
  input  logic [9:0]  asid_i,
  input  logic [18:0] vppn_i,
  output logic        kill_o
);

  logic asid_eq;
  logic va_match;

  // Decide whether the entry is hit by the selected INVTLB flavour
  always_comb begin
    asid_eq  = (key_i.asid == asid_i);
    va_match = (key_i.vppn[18:10] == vppn_i[18:10]) &&
               (key_i.huge_page || (key_i.vppn[9:0] == vppn_i[9:0]));
    kill_o   = 1'b0;
    case (inv_op_i)
      INV_ALL0, INV_ALL1: kill_o = 1'b1;
      INV_GLB:            kill_o = key_i.g;
      INV_NGLB:           kill_o = !key_i.g;
      INV_ASID:           kill_o = !key_i.g && asid_eq;
      INV_ASID_VA:        kill_o = !key_i.g && asid_eq && va_match;
      INV_GVA:            kill_o = (key_i.g || asid_eq) && va_match;
      default:            kill_o = 1'b0;
    endcase
    kill_o = kill_o && key_i.e;
  end

endmodule

// File: rtl/wired_tlb_maint.sv
// TLB maintenance controller: post-reset invalidate sweep, TLBWR/TLBFILL
// single-entry updates and INVTLB resolved by walking a shadow key copy.
module wired_tlb_maint
  import wired0_defines::*;
#(
  parameter  int TLB_ENTRIES = TLB_ENTRIES_DEF,
  localparam int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [IDX_W-1:0]       req_idx_i,
  input  tlb_key_t               req_key_i,
  input  logic [4:0]             inv_op_i,
  input  logic [9:0]             inv_asid_i,
  input  logic [18:0]            inv_vppn_i,
  output logic [TLB_ENTRIES-1:0] upd_o,
  output tlb_key_t               upd_key_o,
  output logic [IDX_W-1:0]       fill_idx_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

  maint_state_e           state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       fill_cnt_q, fill_cnt_d;
  logic [IDX_W-1:0]       fill_idx_q, fill_idx_d;
  logic [TLB_ENTRIES-1:0] upd_q, upd_d;
  tlb_key_t               upd_key_q, upd_key_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  logic [4:0]             inv_op_q, inv_op_d;
  logic [9:0]             inv_asid_q, inv_asid_d;
  logic [18:0]            inv_vppn_q, inv_vppn_d;
  tlb_key_t               shadow_q [TLB_ENTRIES];
  tlb_key_t               shadow_d [TLB_ENTRIES];

  logic                   accept;
  logic [4:0]             cmp_op;
  logic [9:0]             cmp_asid;
  logic [18:0]            cmp_vppn;
  tlb_key_t               cmp_key;
  tlb_key_t               kill_key;
  logic                   kill;

  // Entry 0 is judged in the accept cycle from the live request fields, so
  // the walk finishes N cycles after accept; later entries use latched fields.
  always_comb begin
    accept   = req_valid_i && ready_q;
    cmp_key  = shadow_q[ptr_q];
    cmp_op   = (state_q == ST_WALK) ? inv_op_q   : inv_op_i;
    cmp_asid = (state_q == ST_WALK) ? inv_asid_q : inv_asid_i;
    cmp_vppn = (state_q == ST_WALK) ? inv_vppn_q : inv_vppn_i;
    kill_key   = cmp_key;
    kill_key.e = 1'b0;
  end

  wired_tlb_inv_cmp u_inv_cmp (
    .key_i    (cmp_key),
    .inv_op_i (cmp_op),
    .asid_i   (cmp_asid),
    .vppn_i   (cmp_vppn),
    .kill_o   (kill)
  );

  // Next-state and registered-output computation for the maintenance FSM
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    fill_cnt_d = fill_cnt_q + IDX_W'(1);
    fill_idx_d = fill_idx_q;
    upd_d      = '0;
    upd_key_d  = upd_key_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    inv_op_d   = inv_op_q;
    inv_asid_d = inv_asid_q;
    inv_vppn_d = inv_vppn_q;
    case (state_q)
      ST_INIT: begin
        upd_d[ptr_q] = 1'b1;
        upd_key_d    = '0;
        ptr_d        = ptr_q + IDX_W'(1);
        if (ptr_q == LAST_IDX) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          inv_op_d   = inv_op_i;
          inv_asid_d = inv_asid_i;
          inv_vppn_d = inv_vppn_i;
          state_d    = ST_RESP;
          done_d     = 1'b1;
          case (tlb_maint_op_e'(req_op_i))
            TLB_OP_WR: begin
              upd_d[req_idx_i] = 1'b1;
              upd_key_d        = req_key_i;
            end
            TLB_OP_FILL: begin
              upd_d[fill_cnt_q] = 1'b1;
              upd_key_d         = req_key_i;
              fill_idx_d        = fill_cnt_q;
            end
            TLB_OP_INV: begin
              if (inv_op_i > INV_GVA) begin
                err_d = 1'b1;
              end else begin
                done_d  = 1'b0;
                state_d = ST_WALK;
                ptr_d   = ptr_q + IDX_W'(1);
                if (kill) begin
                  upd_d[ptr_q] = 1'b1;
                  upd_key_d    = kill_key;
                end
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_WALK: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (kill) begin
          upd_d[ptr_q] = 1'b1;
          upd_key_d    = kill_key;
        end
        if (ptr_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Shadow entries follow exactly what is strobed into the match cells
  always_comb begin
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      shadow_d[i] = upd_d[i] ? upd_key_d : shadow_q[i];
    end
  end

  // Control, output and shadow registers; reset aborts any sweep or walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      fill_cnt_q <= '0;
      fill_idx_q <= '0;
      upd_q      <= '0;
      upd_key_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      for (int i = 0; i < TLB_ENTRIES; i++) shadow_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      fill_cnt_q <= fill_cnt_d;
      fill_idx_q <= fill_idx_d;
      upd_q      <= upd_d;
      upd_key_q  <= upd_key_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      for (int i = 0; i < TLB_ENTRIES; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  // Sampled INVTLB operands; pure data, only meaningful during a walk
  always_ff @(posedge clk) begin
    inv_op_q   <= inv_op_d;
    inv_asid_q <= inv_asid_d;
    inv_vppn_q <= inv_vppn_d;
  end

  assign req_ready_o = ready_q;
  assign upd_o       = upd_q;
  assign upd_key_o   = upd_key_q;
  assign fill_idx_o  = fill_idx_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_wired_tlb_maint.sv
// Directed bench for wired_tlb_maint: init sweep, WR, FILL, INVTLB walks,
// error ops and asynchronous reset during a walk.
module tb_wired_tlb_maint;
  import wired0_defines::*;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [4:0]  req_idx_i;
  tlb_key_t    req_key_i;
  logic [4:0]  inv_op_i;
  logic [9:0]  inv_asid_i;
  logic [18:0] inv_vppn_i;
  logic [N-1:0] upd_o;
  tlb_key_t    upd_key_o;
  logic [4:0]  fill_idx_o;
  logic        done_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  wired_tlb_maint #(.TLB_ENTRIES(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_idx_i   (req_idx_i),
    .req_key_i   (req_key_i),
    .inv_op_i    (inv_op_i),
    .inv_asid_i  (inv_asid_i),
    .inv_vppn_i  (inv_vppn_i),
    .upd_o       (upd_o),
    .upd_key_o   (upd_key_o),
    .fill_idx_o  (fill_idx_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  function automatic tlb_key_t mk_key(logic e, logic hp, logic g,
                                      logic [9:0] asid, logic [18:0] vppn);
    tlb_key_t k;
    k.e = e; k.huge_page = hp; k.g = g; k.asid = asid; k.vppn = vppn;
    return k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic init_sweep(input string tag);
    for (int i = 0; i < N; i++) begin
      step();
      chk({tag, "_strobe"}, 64'(upd_o), 64'(32'h1 << i));
      chk({tag, "_key"}, 64'(upd_key_o), 64'h0);
      chk({tag, "_done"}, 64'(done_o), 64'h0);
      chk({tag, "_ready"}, 64'(req_ready_o), 64'(i == N - 1));
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] idx, input tlb_key_t key,
                       input logic [4:0] iop, input logic [9:0] asid, input logic [18:0] vppn);
    req_op_i    = op;
    req_idx_i   = idx;
    req_key_i   = key;
    inv_op_i    = iop;
    inv_asid_i  = asid;
    inv_vppn_i  = vppn;
    req_valid_i = 1'b1;
    chk("ready_at_issue", 64'(req_ready_o), 64'h1);
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic do_wr(input logic [4:0] idx, input tlb_key_t key);
    issue(2'd0, idx, key, 5'd0, 10'd0, 19'd0);
    chk("wr_upd", 64'(upd_o), 64'(32'h1 << idx));
    chk("wr_done", 64'({done_o, err_o}), 64'b10);
    step();
  endtask

  task automatic run_inv(input string tag, input logic [4:0] iop, input logic [9:0] asid,
                         input logic [18:0] vppn, input logic [N-1:0] exp_mask,
                         input tlb_key_t exp_key);
    logic [N-1:0] mask;
    tlb_key_t     last;
    int multi, ebad, dbad;
    mask = '0; last = '0; multi = 0; ebad = 0; dbad = 0;
    issue(2'd2, 5'd0, '0, iop, asid, vppn);
    for (int k = 1; k <= N; k++) begin
      if (k > 1) step();
      mask |= upd_o;
      if ($countones(upd_o) > 1) multi++;
      if (upd_o != '0 && upd_key_o.e) ebad++;
      if (upd_o != '0) last = upd_key_o;
      if (done_o != (k == N)) dbad++;
    end
    chk({tag, "_mask"}, 64'(mask), 64'(exp_mask));
    chk({tag, "_multihot"}, 64'(multi), 64'h0);
    chk({tag, "_e_clear"}, 64'(ebad), 64'h0);
    chk({tag, "_done_timing"}, 64'(dbad), 64'h0);
    chk({tag, "_err"}, 64'(err_o), 64'h0);
    if (exp_mask != '0) chk({tag, "_key"}, 64'(last), 64'(exp_key));
    step();
    chk({tag, "_ready_after"}, 64'(req_ready_o), 64'h1);
  endtask

  initial begin
    tlb_key_t k;
    int dseen;
    rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_idx_i = '0; req_key_i = '0;
    inv_op_i = '0; inv_asid_i = '0; inv_vppn_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_upd", 64'(upd_o), 64'h0);
    chk("rst_key", 64'(upd_key_o), 64'h0);
    chk("rst_flags", 64'({done_o, err_o, req_ready_o}), 64'h0);
    chk("rst_fill_idx", 64'(fill_idx_o), 64'h0);
    rst_n = 1'b1; cyc = 0;
    init_sweep("init");
    step();
    chk("post_init_upd", 64'(upd_o), 64'h0);

    // WR idx 5
    k = mk_key(1'b1, 1'b0, 1'b0, 10'd3, 19'h12345);
    issue(2'd0, 5'd5, k, 5'd0, 10'd0, 19'd0);
    chk("wr5_upd", 64'(upd_o), 64'h20);
    chk("wr5_key", 64'(upd_key_o), 64'(k));
    chk("wr5_done_err", 64'({done_o, err_o}), 64'b10);
    chk("wr5_ready_resp", 64'(req_ready_o), 64'h0);
    step();
    chk("wr5_ready_back", 64'(req_ready_o), 64'h1);
    chk("wr5_done_clear", 64'(done_o), 64'h0);

    // FILL with the free-running counter at 9
    for (int w = 0; w < N && (cyc % N) != 9; w++) step();
    chk("fill_align", 64'(cyc % N), 64'd9);
    k = mk_key(1'b1, 1'b0, 1'b0, 10'd7, 19'h00abc);
    issue(2'd1, 5'd0, k, 5'd0, 10'd0, 19'd0);
    chk("fill_upd", 64'(upd_o), 64'(32'h1 << 9));
    chk("fill_idx", 64'(fill_idx_o), 64'd9);
    chk("fill_key", 64'(upd_key_o), 64'(k));
    chk("fill_done_err", 64'({done_o, err_o}), 64'b10);
    step();

    // INV op4 asid 3: entries 1 and 5 carry asid 3, g=0
    do_wr(5'd1, mk_key(1'b1, 1'b0, 1'b0, 10'd3, 19'h00100));
    do_wr(5'd2, mk_key(1'b1, 1'b0, 1'b0, 10'd4, 19'h00002));
    do_wr(5'd3, mk_key(1'b1, 1'b0, 1'b1, 10'd5, 19'h00001));
    run_inv("inv_asid", 5'd4, 10'd3, 19'd0, 32'h0000_0022,
            mk_key(1'b0, 1'b0, 1'b0, 10'd3, 19'h12345));

    // INV op6 against a huge-page entry, then the same with huge_page=0
    do_wr(5'd7, mk_key(1'b1, 1'b1, 1'b1, 10'd0, 19'h40000));
    run_inv("inv_gva_huge", 5'd6, 10'h3ff, 19'h403ff, 32'h0000_0080,
            mk_key(1'b0, 1'b1, 1'b1, 10'd0, 19'h40000));
    do_wr(5'd7, mk_key(1'b1, 1'b0, 1'b1, 10'd0, 19'h40000));
    run_inv("inv_gva_small", 5'd6, 10'h3ff, 19'h403ff, 32'h0, '0);

    // INV op2: global entries 3 and 7
    run_inv("inv_glb", 5'd2, 10'd0, 19'd0, 32'h0000_0088,
            mk_key(1'b0, 1'b0, 1'b1, 10'd0, 19'h40000));

    // Bad INVTLB op and reserved request op
    issue(2'd2, 5'd0, '0, 5'd9, 10'd0, 19'd0);
    chk("inv9_done_err", 64'({done_o, err_o}), 64'b11);
    chk("inv9_upd", 64'(upd_o), 64'h0);
    step();
    chk("inv9_ready", 64'(req_ready_o), 64'h1);
    issue(2'd3, 5'd4, mk_key(1'b1, 1'b0, 1'b0, 10'd1, 19'd1), 5'd0, 10'd0, 19'd0);
    chk("rsvd_done_err", 64'({done_o, err_o}), 64'b11);
    chk("rsvd_upd", 64'(upd_o), 64'h0);
    step();

    // Async reset while the walk is at entry 10
    dseen = 0;
    issue(2'd2, 5'd0, '0, 5'd0, 10'd0, 19'd0);
    for (int k2 = 1; k2 <= 10; k2++) begin
      if (k2 > 1) step();
      if (done_o) dseen++;
    end
    chk("walk_no_early_done", 64'(dseen), 64'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("midwalk_rst_upd", 64'(upd_o), 64'h0);
    chk("midwalk_rst_key", 64'(upd_key_o), 64'h0);
    chk("midwalk_rst_flags", 64'({done_o, err_o, req_ready_o}), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cyc = 0;
    init_sweep("reinit");
    step();
    k = mk_key(1'b1, 1'b0, 1'b1, 10'd9, 19'h7ffff);
    issue(2'd0, 5'd31, k, 5'd0, 10'd0, 19'd0);
    chk("wr31_upd", 64'(upd_o), 64'h8000_0000);
    chk("wr31_key", 64'(upd_key_o), 64'(k));
    chk("wr31_done_err", 64'({done_o, err_o}), 64'b10);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
